// File: rtl/pipe_rca_pkg.sv
// Shared defaults, stage control flags and configuration check for pipe_rca_adder.
package pipe_rca_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Control half of a stage register; the partial sum and the remaining operand
    // bits shrink/grow per stage, so their widths are declared where the stage is built.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic bit cfg_ok(int unsigned width, int unsigned stages);
        return (stages != 0) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple of full-adder cells; also exposes the carry into its MSB.
module rca_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             cmsb
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co   = c[SLICE];
    assign cmsb = c[SLICE-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder, one SLICE-bit slice per stage, valid/ready on both sides.
// Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_rca_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ready;

    // A stage may load if it is empty or everything downstream of it can move.
    always_comb begin
        logic r;
        r     = out_ready;
        ready = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            r        = r || !v[k];
            ready[k] = r;
        end
    end

    assign in_ready = ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO  = k * SLICE;
        localparam int unsigned REM = WIDTH - LO;

        logic                v_in;
        logic                c_in;
        logic [REM-1:0]      a_in;
        logic [REM-1:0]      b_in;
        logic [SLICE-1:0]    s;
        logic                co;
        logic                cmsb;
        logic [LO+SLICE-1:0] sum_d;
        stage_ctl_t          ctl_q;
        logic [LO+SLICE-1:0] sum_q;
        logic                unused_cmsb;

        assign unused_cmsb = cmsb;

        if (k == 0) begin : g_head
            assign v_in  = in_valid;
            assign c_in  = cin;
            assign a_in  = a;
            assign b_in  = b;
            assign sum_d = s;
        end else begin : g_body
            assign v_in  = g_stage[k-1].ctl_q.valid;
            assign c_in  = g_stage[k-1].ctl_q.carry;
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign sum_d = {s, g_stage[k-1].sum_q};
        end

        rca_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a   (a_in[SLICE-1:0]),
            .b   (b_in[SLICE-1:0]),
            .ci  (c_in),
            .s   (s),
            .co  (co),
            .cmsb(cmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else if (ready[k]) begin
                ctl_q.valid <= v_in;
                if (v_in) begin
                    ctl_q.carry <= co;
                    sum_q       <= sum_d;
                end
            end
        end

        assign v[k] = ctl_q.valid;

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ready[k] && v_in) begin
                    a_q <= a_in[REM-1:SLICE];
                    b_q <= b_in[REM-1:SLICE];
                end
            end
        end else begin : g_tail
            assign out_valid = ctl_q.valid;
            assign sum       = sum_q;
            assign cout      = ctl_q.carry;
`ifdef PIPE_RCA_OVF_EN
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (ready[k] && v_in) begin
                    ovf_q <= cmsb ^ co;
                end
            end

            assign ovf = ovf_q;
`endif
        end
    end

endmodule
